// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, mem_sel size/sign codes,
// FSM state encoding, the MEM/WB entry layout and size/alignment helpers.
package mem_access_stage_pkg;

    localparam int unsigned ADDR_BUS_W     = 32;
    localparam int unsigned DATA_BUS_W     = 32;
    localparam int unsigned REG_ADDR_BUS_W = 5;
    localparam int unsigned MEM_SEL_BUS_W  = 4;
    localparam int unsigned STRB_W         = DATA_BUS_W / 8;

    // mem_sel codes: bit 3 marks unsigned, bits [2:0] encode the size
    localparam logic [MEM_SEL_BUS_W-1:0] MEM_SEL_B  = 4'b0001;
    localparam logic [MEM_SEL_BUS_W-1:0] MEM_SEL_BU = 4'b1001;
    localparam logic [MEM_SEL_BUS_W-1:0] MEM_SEL_H  = 4'b0011;
    localparam logic [MEM_SEL_BUS_W-1:0] MEM_SEL_HU = 4'b1011;
    localparam logic [MEM_SEL_BUS_W-1:0] MEM_SEL_W  = 4'b1111;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_e;

    // MEM/WB pipeline register contents
    typedef struct packed {
        logic [DATA_BUS_W-1:0]     ram_read_data;
        logic                      mem_read;
        logic                      mem_write;
        logic                      mem_ext;
        logic [MEM_SEL_BUS_W-1:0]  mem_sel;
        logic [DATA_BUS_W-1:0]     result;
        logic                      reg_write_en;
        logic [REG_ADDR_BUS_W-1:0] reg_write_addr;
        logic [ADDR_BUS_W-1:0]     pc;
    } wb_entry_t;

    // Access size from a mem_sel code; unknown codes fall back to word
    function automatic mem_size_e sel_size(input logic [MEM_SEL_BUS_W-1:0] sel);
        mem_size_e sz;
        case (sel)
            MEM_SEL_B, MEM_SEL_BU: sz = SZ_B;
            MEM_SEL_H, MEM_SEL_HU: sz = SZ_H;
            default:               sz = SZ_W;
        endcase
        return sz;
    endfunction

    // Half must sit on an even address, word on a multiple of four
    function automatic logic is_misaligned(input mem_size_e sz, input logic [1:0] lsb);
        logic mis;
        case (sz)
            SZ_H:    mis = lsb[0];
            SZ_W:    mis = (lsb != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-RAM request/ready bus.
//   master (MEM stage): ram_en, ram_write_en, ram_addr, ram_write_data out;
//                       ram_ready, ram_read_data in
//   slave  (RAM):       the reverse directions
interface mem_access_stage_if
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_BUS_W,
    parameter int unsigned DATA_WIDTH = DATA_BUS_W
);
    logic                  ram_en;
    logic [STRB_W-1:0]     ram_write_en;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_write_data;
    logic                  ram_ready;
    logic [DATA_WIDTH-1:0] ram_read_data;

    modport master (
        output ram_en, ram_write_en, ram_addr, ram_write_data,
        input  ram_ready, ram_read_data
    );

    modport slave (
        input  ram_en, ram_write_en, ram_addr, ram_write_data,
        output ram_ready, ram_read_data
    );
endinterface

// File: rtl/mem_store_align.sv
// Store lane alignment (combinational).
//   mem_sel_i  : size/sign code
//   addr_lsb_i : byte offset within the word
//   data_i     : store data (rs2)
//   strb_o     : byte write strobes
//   data_o     : store data replicated across all lanes of its size
module mem_store_align
    import mem_access_stage_pkg::*;
(
    input  logic [MEM_SEL_BUS_W-1:0] mem_sel_i,
    input  logic [1:0]               addr_lsb_i,
    input  logic [DATA_BUS_W-1:0]    data_i,
    output logic [STRB_W-1:0]        strb_o,
    output logic [DATA_BUS_W-1:0]    data_o
);

    always_comb begin
        strb_o = 4'b1111;
        data_o = data_i;
        case (sel_size(mem_sel_i))
            SZ_B: begin
                strb_o = STRB_W'(4'b0001 << addr_lsb_i);
                data_o = {4{data_i[7:0]}};
            end
            SZ_H: begin
                // addr[0] is ignored: a misaligned half lands on its aligned pair
                strb_o = addr_lsb_i[1] ? 4'b1100 : 4'b0011;
                data_o = {2{data_i[15:0]}};
            end
            default: begin
                strb_o = 4'b1111;
                data_o = data_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage core, including the MEM/WB pipeline register.
// Issues data-RAM requests, stalls upstream until ram_ready, then registers
// load data and control for WB. Non-memory instructions take one cycle.
//   clk, rst            : clock, synchronous active-high reset
//   flush               : squash the instruction in MEM
//   *_in                : EX/MEM register contents
//   ram_bus (master)    : data-RAM request/ready bus
//   stall_req           : freeze PC/IF/ID/EX/EX-MEM (combinational)
//   wb_*                : MEM/WB register outputs
//   misalign_exc        : only with MEM_MISALIGN_TRAP_EN; one-cycle trap flag
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses instead of issuing them.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = ADDR_BUS_W,
    parameter int unsigned DATA_WIDTH     = DATA_BUS_W,
    parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_BUS_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      mem_read_flag_in,
    input  logic                      mem_write_flag_in,
    input  logic                      mem_ext_flag_in,
    input  logic [MEM_SEL_BUS_W-1:0]  mem_sel_in,
    input  logic [DATA_WIDTH-1:0]     mem_write_data_in,
    input  logic [DATA_WIDTH-1:0]     result_in,
    input  logic                      reg_write_en_in,
    input  logic [REG_ADDR_WIDTH-1:0] reg_write_addr_in,
    input  logic [ADDR_WIDTH-1:0]     current_pc_addr_in,
    mem_access_stage_if.master        ram_bus,
    output logic                      stall_req,
    output logic [DATA_WIDTH-1:0]     wb_ram_read_data,
    output logic                      wb_mem_read_flag,
    output logic                      wb_mem_write_flag,
    output logic                      wb_mem_ext_flag,
    output logic [MEM_SEL_BUS_W-1:0]  wb_mem_sel,
    output logic [DATA_WIDTH-1:0]     wb_result,
    output logic                      wb_reg_write_en,
    output logic [REG_ADDR_WIDTH-1:0] wb_reg_write_addr,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                      misalign_exc,
`endif
    output logic [ADDR_WIDTH-1:0]     wb_pc_addr
);

    mem_state_e state_q;
    logic       flushed_q;
    wb_entry_t  wb_q;

    logic              mem_op;
    logic              is_load;
    logic              misalign;
    logic              req;
    logic              stall;
    logic              done;
    logic              kill;
    logic              idle_flush;
    logic [STRB_W-1:0] store_strb;
    logic [DATA_WIDTH-1:0] store_data;

    mem_store_align u_store_align (
        .mem_sel_i  (mem_sel_in),
        .addr_lsb_i (result_in[1:0]),
        .data_i     (mem_write_data_in),
        .strb_o     (store_strb),
        .data_o     (store_data)
    );

    // Request / stall decode; both flags high is handled as a store
    always_comb begin
        mem_op     = mem_read_flag_in | mem_write_flag_in;
        is_load    = mem_read_flag_in & ~mem_write_flag_in;
        misalign   = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign   = mem_op & is_misaligned(sel_size(mem_sel_in), result_in[1:0]);
`endif
        req        = 1'b0;
        if (!rst) begin
            if (state_q == WAIT) begin
                req = 1'b1;
            end else begin
                req = mem_op & ~flush & ~misalign;
            end
        end
        stall      = req & ~ram_bus.ram_ready;
        done       = req & ram_bus.ram_ready;
        // A flush seen earlier in WAIT still squashes the entry captured on ready
        kill       = flush | flushed_q | misalign;
        idle_flush = flush & (state_q == IDLE);
    end

    // RAM bus drive; inputs are frozen upstream while in WAIT
    always_comb begin
        ram_bus.ram_en         = req;
        ram_bus.ram_addr       = {result_in[ADDR_WIDTH-1:2], 2'b00};
        ram_bus.ram_write_en   = (req & mem_write_flag_in) ? store_strb : '0;
        ram_bus.ram_write_data = store_data;
        stall_req              = stall;
    end

    // FSM and MEM/WB register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            flushed_q <= 1'b0;
            wb_q      <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_exc <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE:    if (stall) state_q <= WAIT;
                WAIT:    if (ram_bus.ram_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            flushed_q <= (state_q == WAIT) & ~ram_bus.ram_ready & (flush | flushed_q);

            if (stall) begin
                // bubble: clear enables/flags, keep data fields
                wb_q.mem_read     <= 1'b0;
                wb_q.mem_write    <= 1'b0;
                wb_q.mem_ext      <= 1'b0;
                wb_q.reg_write_en <= 1'b0;
            end else begin
                wb_q.mem_read     <= is_load & ~kill;
                wb_q.mem_write    <= mem_write_flag_in & ~kill;
                wb_q.mem_ext      <= mem_ext_flag_in & ~kill;
                wb_q.reg_write_en <= reg_write_en_in & ~kill;
                if (!idle_flush) begin
                    wb_q.mem_sel        <= mem_sel_in;
                    wb_q.result         <= result_in;
                    wb_q.reg_write_addr <= reg_write_addr_in;
                    wb_q.pc             <= current_pc_addr_in;
                end
            end

            if (done & is_load) begin
                wb_q.ram_read_data <= ram_bus.ram_read_data;
            end
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_exc <= misalign & ~flush;
`endif
        end
    end

    assign wb_ram_read_data  = wb_q.ram_read_data;
    assign wb_mem_read_flag  = wb_q.mem_read;
    assign wb_mem_write_flag = wb_q.mem_write;
    assign wb_mem_ext_flag   = wb_q.mem_ext;
    assign wb_mem_sel        = wb_q.mem_sel;
    assign wb_result         = wb_q.result;
    assign wb_reg_write_en   = wb_q.reg_write_en;
    assign wb_reg_write_addr = wb_q.reg_write_addr;
    assign wb_pc_addr        = wb_q.pc;

endmodule
